// File: rtl/mileage_counter.sv
// mileage_counter: odometer for the manual driving stage. It decodes the
// motion requests into a drive state, counts clk cycles of sustained motion
// with a prescaler, and advances a six-digit BCD mileage each time
// TICKS_PER_UNIT moving cycles have elapsed.
//
// Ports:
//   clk                  system clock, rising-edge active
//   rst                  synchronous active-high reset (highest priority)
//   power                vehicle powered
//   move_forward_signal  forward motion request
//   move_backward_signal backward motion request
//   clear                synchronous odometer clear (mileage, prescaler, overflow)
//   mileage_bcd          six BCD digits, digit 0 in [3:0]
//   drive_state          OFF=00, STOPPED=01, MOVING=10, FAULT=11
//   unit_pulse           one-cycle strobe on each mileage increment
//   overflow             sticky flag, set when mileage wraps 999999 -> 000000
module mileage_counter #(
  parameter int unsigned TICKS_PER_UNIT = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        power,
  input  logic        move_forward_signal,
  input  logic        move_backward_signal,
  input  logic        clear,
  output logic [23:0] mileage_bcd,
  output logic [1:0]  drive_state,
  output logic        unit_pulse,
  output logic        overflow
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'b00,
    ST_STOPPED = 2'b01,
    ST_MOVING  = 2'b10,
    ST_FAULT   = 2'b11
  } state_t;

  localparam logic [26:0] TICK_LAST = 27'(TICKS_PER_UNIT - 1);

  state_t      state_q, state_d;
  logic [26:0] prescale_q, prescale_d;
  logic [23:0] mileage_d, mileage_inc;
  logic        overflow_d, pulse_d;
  logic        fwd, bwd, conflict;
  logic        counting, unit_done;
  logic        bcd_carry;

  assign fwd      = power & move_forward_signal & ~move_backward_signal;
  assign bwd      = power & move_backward_signal & ~move_forward_signal;
  assign conflict = power & move_forward_signal & move_backward_signal;

  // Next state depends only on the inputs, so every transition is one cycle.
  always_comb begin
    state_d = ST_STOPPED;
    if (!power)          state_d = ST_OFF;
    else if (conflict)   state_d = ST_FAULT;
    else if (fwd || bwd) state_d = ST_MOVING;
  end

  // Only cycles that stay in MOVING accumulate distance.
  assign counting  = (state_q == ST_MOVING) && (state_d == ST_MOVING);
  assign unit_done = counting && (prescale_q == TICK_LAST);

  // Ripple BCD increment; carry out of digit 5 marks the 999999 wrap.
  always_comb begin
    mileage_inc = mileage_bcd;
    bcd_carry   = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (bcd_carry) begin
        if (mileage_bcd[4*i +: 4] == 4'd9) begin
          mileage_inc[4*i +: 4] = '0;
        end else begin
          mileage_inc[4*i +: 4] = mileage_bcd[4*i +: 4] + 4'd1;
          bcd_carry             = 1'b0;
        end
      end
    end
  end

  always_comb begin
    prescale_d = prescale_q;
    mileage_d  = mileage_bcd;
    overflow_d = overflow;
    pulse_d    = 1'b0;
    if (clear) begin
      // Clear wins over a coincident unit completion: no strobe, no count.
      prescale_d = '0;
      mileage_d  = '0;
      overflow_d = 1'b0;
    end else if (state_d == ST_OFF) begin
      // Losing power discards any partial unit.
      prescale_d = '0;
    end else if (counting) begin
      if (unit_done) begin
        prescale_d = '0;
        mileage_d  = mileage_inc;
        pulse_d    = 1'b1;
        if (bcd_carry) overflow_d = 1'b1;
      end else begin
        prescale_d = prescale_q + 27'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OFF;
      prescale_q  <= '0;
      mileage_bcd <= '0;
      overflow    <= 1'b0;
      unit_pulse  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescale_q  <= prescale_d;
      mileage_bcd <= mileage_d;
      overflow    <= overflow_d;
      unit_pulse  <= pulse_d;
    end
  end

  assign drive_state = state_q;

endmodule

// File: tb/tb_mileage_counter.sv
// tb_mileage_counter: directed bench for mileage_counter with TICKS_PER_UNIT=4.
// Expected values are hand-computed from the odometer behaviour; large mileage
// values are preloaded by briefly forcing the mileage register while stopped.
module tb_mileage_counter;

  logic        clk;
  logic        rst;
  logic        power;
  logic        move_forward_signal;
  logic        move_backward_signal;
  logic        clear;
  logic [23:0] mileage_bcd;
  logic [1:0]  drive_state;
  logic        unit_pulse;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  mileage_counter #(.TICKS_PER_UNIT(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .power                (power),
    .move_forward_signal  (move_forward_signal),
    .move_backward_signal (move_backward_signal),
    .clear                (clear),
    .mileage_bcd          (mileage_bcd),
    .drive_state          (drive_state),
    .unit_pulse           (unit_pulse),
    .overflow             (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit later.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Load a mileage value while the vehicle is stopped (mileage holds).
  task automatic preload(input logic [23:0] v);
    force dut.mileage_bcd = v;
    step(1);
    release dut.mileage_bcd;
  endtask

  initial begin
    rst = 1'b1; power = 1'b0; move_forward_signal = 1'b0;
    move_backward_signal = 1'b0; clear = 1'b0;
    step(2);
    check("rst_state",    32'(drive_state), 32'h0);
    check("rst_mileage",  32'(mileage_bcd), 32'h0);
    check("rst_pulse",    32'(unit_pulse),  32'h0);
    check("rst_overflow", 32'(overflow),    32'h0);
    rst = 1'b0;

    // Basic count: strobes on the 4th and 8th moving cycles.
    power = 1'b1; move_forward_signal = 1'b1;
    step(1);
    check("basic_enter", 32'(drive_state), 32'h2);
    check("basic_enter_pulse", 32'(unit_pulse), 32'h0);
    for (int k = 1; k <= 9; k++) begin
      step(1);
      check($sformatf("basic_pulse_%0d", k), 32'(unit_pulse), (k == 4 || k == 8) ? 32'h1 : 32'h0);
    end
    check("basic_mileage", 32'(mileage_bcd), 32'h000002);
    check("basic_state",   32'(drive_state), 32'h2);

    // Stop and clear: clear leaves drive_state alone.
    move_forward_signal = 1'b0; clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_state",   32'(drive_state), 32'h1);
    check("clr_mileage", 32'(mileage_bcd), 32'h0);

    // BCD carry 9 -> 10.
    move_forward_signal = 1'b1;
    step(1);
    step(36);
    check("carry_9", 32'(mileage_bcd), 32'h000009);
    step(4);
    check("carry_10", 32'(mileage_bcd), 32'h000010);
    check("carry_10_pulse", 32'(unit_pulse), 32'h1);

    // 99 -> 100.
    move_forward_signal = 1'b0;
    step(1);
    preload(24'h000099);
    check("preload_99", 32'(mileage_bcd), 32'h000099);
    move_forward_signal = 1'b1;
    step(1);
    step(4);
    check("carry_100", 32'(mileage_bcd), 32'h000100);

    // 099999 -> 100000.
    move_forward_signal = 1'b0;
    step(1);
    preload(24'h099999);
    move_forward_signal = 1'b1;
    step(1);
    step(4);
    check("carry_100000", 32'(mileage_bcd), 32'h100000);
    check("carry_100000_ovf", 32'(overflow), 32'h0);

    // Conflict: prescaler holds at 2 through FAULT, resumes on backward motion.
    step(2);
    move_backward_signal = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check($sformatf("fault_state_%0d", k), 32'(drive_state), 32'h3);
      check($sformatf("fault_pulse_%0d", k), 32'(unit_pulse), 32'h0);
    end
    check("fault_mileage", 32'(mileage_bcd), 32'h100000);
    move_forward_signal = 1'b0;
    step(1);
    check("bwd_state", 32'(drive_state), 32'h2);
    check("bwd_pulse_a", 32'(unit_pulse), 32'h0);
    step(1);
    check("bwd_pulse_b", 32'(unit_pulse), 32'h0);
    step(1);
    check("bwd_pulse_c", 32'(unit_pulse), 32'h1);
    check("bwd_mileage", 32'(mileage_bcd), 32'h100001);

    // Power drop after 3 moving cycles discards the partial unit.
    move_forward_signal = 1'b1; move_backward_signal = 1'b0;
    step(3);
    check("pdrop_pre", 32'(unit_pulse), 32'h0);
    power = 1'b0;
    step(1);
    check("pdrop_off", 32'(drive_state), 32'h0);
    power = 1'b1;
    step(1);
    check("pdrop_back", 32'(drive_state), 32'h2);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check($sformatf("pdrop_pulse_%0d", k), 32'(unit_pulse), (k == 4) ? 32'h1 : 32'h0);
    end
    check("pdrop_mileage", 32'(mileage_bcd), 32'h100002);

    // Wrap from 999999, then clear on the next unit's completing edge.
    move_forward_signal = 1'b0;
    step(1);
    preload(24'h999999);
    move_forward_signal = 1'b1;
    step(1);
    step(4);
    check("wrap_mileage", 32'(mileage_bcd), 32'h000000);
    check("wrap_ovf",     32'(overflow),    32'h1);
    check("wrap_pulse",   32'(unit_pulse),  32'h1);
    step(3);
    check("ovf_sticky", 32'(overflow), 32'h1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("wclr_mileage", 32'(mileage_bcd), 32'h000000);
    check("wclr_ovf",     32'(overflow),    32'h0);
    check("wclr_pulse",   32'(unit_pulse),  32'h0);
    check("wclr_state",   32'(drive_state), 32'h2);

    // Reset with the prescaler at 3: no strobe, counting restarts from 0.
    step(4);
    check("pre_rst_mileage", 32'(mileage_bcd), 32'h000001);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mrst_state",   32'(drive_state), 32'h0);
    check("mrst_mileage", 32'(mileage_bcd), 32'h0);
    check("mrst_pulse",   32'(unit_pulse),  32'h0);
    check("mrst_ovf",     32'(overflow),    32'h0);
    step(1);
    check("post_rst_state", 32'(drive_state), 32'h2);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check($sformatf("post_rst_pulse_%0d", k), 32'(unit_pulse), (k == 4) ? 32'h1 : 32'h0);
    end
    check("post_rst_mileage", 32'(mileage_bcd), 32'h000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
